// File: rtl/beep_seq_pkg.sv
// Shared types and constants for the beep melody sequencer.
// The BEEP_SEQ_GAP_EN macro adds the GAP state used for silent inter-note gaps.
package beep_seq_pkg;

  localparam int PITCH_W     = 3;
  localparam int BEATS_W     = 3;
  localparam int ENTRY_W     = PITCH_W + BEATS_W;
  localparam int PERIOD_W    = 18;
  localparam int IDX_W       = 4;
  localparam int TABLE_DEPTH = 16;
  localparam int BEAT_CNT_W  = 25;
  localparam int GAP_CNT_W   = 20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    DONE = 3'd3
`ifdef BEEP_SEQ_GAP_EN
    , GAP = 3'd4
`endif
  } beep_state_e;

  localparam logic [PITCH_W-1:0] PITCH_REST = 3'd0;
  localparam logic [PITCH_W-1:0] PITCH_DO   = 3'd1;
  localparam logic [PITCH_W-1:0] PITCH_RE   = 3'd2;
  localparam logic [PITCH_W-1:0] PITCH_MI   = 3'd3;
  localparam logic [PITCH_W-1:0] PITCH_FA   = 3'd4;
  localparam logic [PITCH_W-1:0] PITCH_SO   = 3'd5;
  localparam logic [PITCH_W-1:0] PITCH_LA   = 3'd6;
  localparam logic [PITCH_W-1:0] PITCH_XI   = 3'd7;

  localparam logic [BEATS_W-1:0] ONE_BEAT = 3'd1;

  // Entry i occupies bits [i*ENTRY_W +: ENTRY_W]; listed here from entry 15 down to entry 0.
  localparam logic [TABLE_DEPTH*ENTRY_W-1:0] DEFAULT_SONG = {
    {PITCH_REST, ONE_BEAT}, {PITCH_DO, ONE_BEAT}, {PITCH_RE, ONE_BEAT}, {PITCH_MI, ONE_BEAT},
    {PITCH_FA,   ONE_BEAT}, {PITCH_SO, ONE_BEAT}, {PITCH_LA, ONE_BEAT}, {PITCH_XI, ONE_BEAT},
    {PITCH_REST, ONE_BEAT}, {PITCH_XI, ONE_BEAT}, {PITCH_LA, ONE_BEAT}, {PITCH_SO, ONE_BEAT},
    {PITCH_FA,   ONE_BEAT}, {PITCH_MI, ONE_BEAT}, {PITCH_RE, ONE_BEAT}, {PITCH_DO, ONE_BEAT}
  };

  function automatic logic [PERIOD_W-1:0] pitch_period(input logic [PITCH_W-1:0] pitch);
    case (pitch)
      PITCH_DO: return 18'd190839;
      PITCH_RE: return 18'd170067;
      PITCH_MI: return 18'd151514;
      PITCH_FA: return 18'd143265;
      PITCH_SO: return 18'd127550;
      PITCH_LA: return 18'd113635;
      PITCH_XI: return 18'd101213;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/beep_seq_rom.sv
// Combinational 16-entry song table; each entry is {pitch, beats}.
module beep_seq_rom
  import beep_seq_pkg::*;
#(
  parameter logic [TABLE_DEPTH*ENTRY_W-1:0] SONG_TABLE = DEFAULT_SONG
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] entry
);

  assign entry = SONG_TABLE[idx*ENTRY_W +: ENTRY_W];

endmodule

// File: rtl/beep_seq_ctrl.sv
// Melody sequencer: walks the song table and drives the tone generator period/enable.
// Define BEEP_SEQ_GAP_EN to insert a silent gap of GAP_CNT_MAX+1 cycles after every note.
module beep_seq_ctrl
  import beep_seq_pkg::*;
#(
  parameter logic [BEAT_CNT_W-1:0]          BEAT_CNT_MAX = 25'd12_499_999,
  parameter logic [4:0]                     SONG_LEN     = 5'd16,
  parameter logic [TABLE_DEPTH*ENTRY_W-1:0] SONG_TABLE   = DEFAULT_SONG
`ifdef BEEP_SEQ_GAP_EN
  , parameter logic [GAP_CNT_W-1:0]         GAP_CNT_MAX  = 20'd999_999
`endif
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  output logic [PERIOD_W-1:0] note_period,
  output logic                note_valid,
  output logic [IDX_W-1:0]    note_idx,
  output logic                busy,
  output logic                done,
  output beep_state_e         dbg_state
);

  beep_state_e             state, state_d;
  logic [IDX_W-1:0]        idx_d;
  logic [PERIOD_W-1:0]     period_d;
  logic                    valid_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt, beat_cnt_d;
  logic [BEATS_W-1:0]      beat_left, beat_left_d;
  logic                    advance;
  logic [ENTRY_W-1:0]      entry;
  logic [PITCH_W-1:0]      entry_pitch;
  logic [BEATS_W-1:0]      entry_beats;
`ifdef BEEP_SEQ_GAP_EN
  logic [GAP_CNT_W-1:0]    gap_cnt, gap_cnt_d;
`endif

  beep_seq_rom #(.SONG_TABLE(SONG_TABLE)) u_rom (
    .idx   (note_idx),
    .entry (entry)
  );

  assign entry_pitch = entry[ENTRY_W-1:BEATS_W];
  assign entry_beats = entry[BEATS_W-1:0];
  assign dbg_state   = state;

  always_comb begin
    state_d     = state;
    idx_d       = note_idx;
    period_d    = note_period;
    valid_d     = note_valid;
    beat_cnt_d  = beat_cnt;
    beat_left_d = beat_left;
`ifdef BEEP_SEQ_GAP_EN
    gap_cnt_d   = gap_cnt;
`endif
    advance     = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        state_d     = PLAY;
        period_d    = pitch_period(entry_pitch);
        valid_d     = (entry_pitch != PITCH_REST);
        beat_left_d = (entry_beats == '0) ? 3'd1 : entry_beats;
        beat_cnt_d  = '0;
      end
      PLAY: begin
        if (beat_cnt == BEAT_CNT_MAX) begin
          beat_cnt_d  = '0;
          beat_left_d = beat_left - 3'd1;
          if (beat_left == 3'd1) begin
            valid_d = 1'b0;
`ifdef BEEP_SEQ_GAP_EN
            state_d   = GAP;
            gap_cnt_d = '0;
`else
            advance = 1'b1;
`endif
          end
        end else begin
          beat_cnt_d = beat_cnt + 25'd1;
        end
      end
`ifdef BEEP_SEQ_GAP_EN
      GAP: begin
        if (gap_cnt == GAP_CNT_MAX) advance = 1'b1;
        else gap_cnt_d = gap_cnt + 20'd1;
      end
`endif
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // loop_en only matters when the last entry finishes.
    if (advance) begin
      if ({1'b0, note_idx} < SONG_LEN - 5'd1) begin
        idx_d   = note_idx + 4'd1;
        state_d = LOAD;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = LOAD;
      end else begin
        state_d = DONE;
      end
    end

    // stop overrides everything, including a note ending on the same cycle.
    if (stop && state != IDLE) begin
      state_d     = IDLE;
      idx_d       = '0;
      valid_d     = 1'b0;
      period_d    = '0;
      beat_cnt_d  = '0;
      beat_left_d = '0;
`ifdef BEEP_SEQ_GAP_EN
      gap_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      note_idx    <= '0;
      note_period <= '0;
      note_valid  <= 1'b0;
      beat_cnt    <= '0;
      beat_left   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef BEEP_SEQ_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      note_idx    <= idx_d;
      note_period <= period_d;
      note_valid  <= valid_d;
      beat_cnt    <= beat_cnt_d;
      beat_left   <= beat_left_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
`ifdef BEEP_SEQ_GAP_EN
      gap_cnt     <= gap_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_beep_seq_ctrl.sv
// Bench for beep_seq_ctrl with a 4-entry song and 10-cycle beats; expected per-cycle outputs are queued.
module tb_beep_seq_ctrl;
  import beep_seq_pkg::*;

  localparam int W = 26;
`ifdef BEEP_SEQ_GAP_EN
  localparam int GAPN = 4;
`else
  localparam int GAPN = 0;
`endif
  localparam logic [95:0] TB_TABLE = {72'd0, 6'b011_000, 6'b000_001, 6'b010_010, 6'b001_001};

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                loop_en = 1'b0;
  logic [17:0]         note_period;
  logic                note_valid;
  logic [3:0]          note_idx;
  logic                busy;
  logic                done;
  beep_state_e         dbg_state;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  int          tb_pitch [4] = '{1, 2, 0, 3};
  int          tb_beats [4] = '{1, 2, 1, 0};
  logic [17:0] per_tab  [8] = '{18'd0, 18'd190839, 18'd170067, 18'd151514,
                                18'd143265, 18'd127550, 18'd113635, 18'd101213};

  // clock / reset
  always #10 sys_clk = ~sys_clk;

  beep_seq_ctrl #(
    .BEAT_CNT_MAX (25'd9),
    .SONG_LEN     (5'd4),
    .SONG_TABLE   (TB_TABLE)
`ifdef BEEP_SEQ_GAP_EN
    , .GAP_CNT_MAX (20'd3)
`endif
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .note_period (note_period),
    .note_valid  (note_valid),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Vector layout: {period_checked, busy, done, valid, idx[3:0], period[17:0]}
  task automatic push_vec(input bit care, input bit b, input bit d, input bit v,
                          input logic [3:0] idx, input logic [17:0] per);
    exp_q.push_back({care, b, d, v, idx, care ? per : 18'd0});
  endtask

  task automatic push_note(input int i);
    int nb;
    logic [3:0] idx;
    nb  = (tb_beats[i] == 0) ? 1 : tb_beats[i];
    idx = i[3:0];
    push_vec(1'b0, 1'b1, 1'b0, 1'b0, idx, 18'd0);
    for (int c = 0; c < nb * 10; c++)
      push_vec(1'b1, 1'b1, 1'b0, tb_pitch[i] != 0, idx, per_tab[tb_pitch[i]]);
    for (int c = 0; c < GAPN; c++)
      push_vec(1'b0, 1'b1, 1'b0, 1'b0, idx, 18'd0);
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) push_vec(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_v, obs_v;
    exp_q.delete();
    for (int c = 0; c < 4; c++) push_vec(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      n_vec++;
      if (dbg_state !== IDLE) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %0d expected %0d", k, dbg_state, IDLE);
      end
      sys_rst = 1'b0;
      stop    = (k == 1);
    end
    stop = 1'b0;
  endtask

  // Full song; extra start pulses mid-song and a transient loop_en must not change anything.
  task automatic test_full_song();
    logic [W-1:0] exp_v, obs_v;
    int n;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_note(i);
    push_vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 18'd0);
    push_idle(3);
    n = exp_q.size();
    @(negedge sys_clk);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL full_song[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      start   = (k == 5) || (k == 11) || (k == 30);
      loop_en = (k >= 3) && (k <= 20);
    end
    start   = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic test_loop();
    logic [W-1:0] exp_v, obs_v;
    int n, kstop;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_note(i);
    kstop = exp_q.size() + 5;
    push_note(0);
    while (exp_q.size() > kstop + 1) void'(exp_q.pop_back());
    push_idle(3);
    n = exp_q.size();
    @(negedge sys_clk);
    start   = 1'b1;
    loop_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL loop[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      stop = (k == kstop);
    end
    stop    = 1'b0;
    loop_en = 1'b0;
  endtask

  // stop during the second beat of RE.
  task automatic test_stop();
    logic [W-1:0] exp_v, obs_v;
    int n, kstop;
    exp_q.delete();
    push_note(0);
    push_note(1);
    kstop = 25 + GAPN;
    while (exp_q.size() > kstop + 1) void'(exp_q.pop_back());
    push_idle(3);
    n = exp_q.size();
    @(negedge sys_clk);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL stop[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      stop = (k == kstop);
    end
    stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    logic [W-1:0] exp_v, obs_v;
    exp_q.delete();
    push_idle(3);
    @(negedge sys_clk);
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      stop  = 1'b0;
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL start_stop_idle[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      n_vec++;
      if (dbg_state !== IDLE) begin
        n_err++;
        $display("FAIL start_stop_state[%0d]: got %0d expected %0d", k, dbg_state, IDLE);
      end
    end
  endtask

  task automatic test_reset_mid_song();
    logic [W-1:0] exp_v, obs_v;
    int n;
    exp_q.delete();
    push_note(0);
    push_note(1);
    while (exp_q.size() > 15) void'(exp_q.pop_back());
    for (int c = 0; c < 2; c++) push_vec(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 18'd0);
    n = exp_q.size();
    @(negedge sys_clk);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs_v = {exp_v[W-1], busy, done, note_valid, note_idx, exp_v[W-1] ? note_period : 18'd0};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_song[%0d]: got %h expected %h", k, obs_v, exp_v);
      end
      sys_rst = (k == 14);
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_song();
    test_loop();
    test_stop();
    test_start_stop_idle();
    test_reset_mid_song();
    repeat (2) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
